// File: rtl/ps2_receive.sv
// PS/2 device-to-host receiver: clock filter, frame FSM with timeout, and a byte FIFO.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity are discarded.
module ps2_receive #(
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_sync,
    input  logic       ps2_data_sync,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_read,
    output logic       frame_error,
    output logic       overrun
);
    localparam int FW = $clog2(FILTER_CYCLES);
    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          filt, filt_prev;
    logic [FW-1:0] fcnt;
    logic          fall;
    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          parity_ok, push, pop, full, empty;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;

    // Filtered clock only moves after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            fcnt      <= '0;
        end else begin
            filt_prev <= filt;
            if (ps2_clk_sync == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_CYCLES - 1)) begin
                filt <= ~filt;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    assign parity_ok = ^{shift, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    assign push = fall && (state == STOP) && ps2_data_sync && parity_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            frame_error <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            frame_error <= 1'b0;
            if (state == IDLE) begin
                to_cnt <= '0;
                if (fall && !ps2_data_sync) begin
                    shift   <= '0;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
            end else if (fall) begin
                to_cnt <= '0;
                case (state)
                    DATA: begin
                        shift   <= {ps2_data_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_bit <= ps2_data_sync;
`endif
                        state <= STOP;
                    end
                    default: begin
                        frame_error <= ~(ps2_data_sync & parity_ok);
                        state       <= IDLE;
                    end
                endcase
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // Device stalled mid-frame: abandon it.
                frame_error <= 1'b1;
                state       <= IDLE;
                to_cnt      <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_valid = ~empty;
    assign pop      = rx_read & rx_valid;
    assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    // When full, a same-cycle pop frees the slot the push overwrites.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push & full & ~pop;
            if (push && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_receive.sv
// Directed bench for ps2_receive: frames driven bit by bit, pulses counted on the falling clock edge.
module tb_ps2_receive;
    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk_sync = 1'b1;
    logic       ps2_data_sync = 1'b1;
    logic       rx_read = 1'b0;
    logic       rx_valid, frame_error, overrun;
    logic [7:0] rx_data;

    int n_tests = 0, n_fail = 0;
    int n_err = 0, n_ovr = 0;
    int e0;

    ps2_receive #(.FILTER_CYCLES(4), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .ps2_clk_sync(ps2_clk_sync), .ps2_data_sync(ps2_data_sync),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_read(rx_read),
        .frame_error(frame_error), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_error) n_err++;
        if (overrun) n_ovr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ps2_data_sync = bits[i];
            repeat (20) @(negedge clk);
            ps2_clk_sync = 1'b0;
            repeat (20) @(negedge clk);
            ps2_clk_sync = 1'b1;
        end
    endtask

    // Stop-bit clock: optionally checks push latency or pops during the push cycle.
    task automatic stop_bit(input logic s, input bit lat, input bit do_pop, input logic [7:0] exp);
        ps2_data_sync = s;
        repeat (20) @(negedge clk);
        ps2_clk_sync = 1'b0;
        repeat (4) @(negedge clk);
        if (lat) chk("lat_valid_c4", rx_valid, 0);
        if (do_pop) rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        if (lat) begin
            chk("lat_valid_c5", rx_valid, 1);
            chk("lat_data_c5", rx_data, exp);
        end
        repeat (15) @(negedge clk);
        ps2_clk_sync = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bits(frame(d, p, s), 0, 9);
        stop_bit(s, 0, 0, 8'h00);
    endtask

    task automatic good_frame(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1);
    endtask

    task automatic drain(input logic [7:0] exp);
        chk("drain_valid", rx_valid, 1);
        chk("drain_data", rx_data, exp);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        chk(tag, {rx_valid, rx_data}, 9'h000);
    endtask

    task automatic glitch();
        repeat (10) @(negedge clk);
        ps2_clk_sync = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk_sync = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_empty("reset_rx");
        chk("reset_ferr", frame_error, 0);
        chk("reset_ovr", overrun, 0);

        // Valid byte with latency check, then single pop
        send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 9);
        stop_bit(1'b1, 1, 0, 8'h1C);
        chk("valid_no_err", n_err, 0);
        drain(8'h1C);
        chk_empty("after_pop");

        // Bad parity
        e0 = n_err;
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        chk("badpar_err", n_err - e0, 1);
        chk_empty("badpar_empty");
`else
        chk("badpar_noerr", n_err - e0, 0);
        drain(8'h1C);
        chk_empty("badpar_drained");
`endif

        // Bad stop
        e0 = n_err;
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("badstop_err", n_err - e0, 1);
        chk_empty("badstop_empty");

        // Timeout after start + 5 data bits
        e0 = n_err;
        send_bits(frame(8'hF0, 1'b1, 1'b1), 0, 5);
        repeat (TO + 20) @(negedge clk);
        chk("timeout_err", n_err - e0, 1);
        chk_empty("timeout_empty");
        e0 = n_err;
        good_frame(8'hF0);
        chk("after_to_noerr", n_err - e0, 0);
        drain(8'hF0);

        // Glitch rejection while idle and mid-frame
        e0 = n_err;
        glitch();
        chk_empty("glitch_idle");
        send_bits(frame(8'hAA, 1'b1, 1'b1), 0, 3);
        glitch();
        send_bits(frame(8'hAA, 1'b1, 1'b1), 4, 9);
        stop_bit(1'b1, 0, 0, 8'h00);
        chk("glitch_noerr", n_err - e0, 0);
        drain(8'hAA);
        chk_empty("glitch_drained");

        // Reset mid-frame drops it silently
        e0 = n_err;
        send_bits(frame(8'h33, 1'b1, 1'b1), 0, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (TO + 20) @(negedge clk);
        chk("midreset_noerr", n_err - e0, 0);
        chk_empty("midreset_empty");
        good_frame(8'h55);
        drain(8'h55);

        // Overrun: 9 frames, no reads
        e0 = n_ovr;
        for (int i = 1; i <= 9; i++) good_frame(8'(i));
        chk("overrun_once", n_ovr - e0, 1);
        for (int i = 1; i <= 8; i++) drain(8'(i));
        chk_empty("overrun_drained");

        // Full with pop in the push cycle
        e0 = n_ovr;
        for (int i = 1; i <= 8; i++) good_frame(8'(i));
        send_bits(frame(8'h09, 1'b1, 1'b1), 0, 9);
        stop_bit(1'b1, 0, 1, 8'h00);
        chk("fullpop_no_ovr", n_ovr - e0, 0);
        for (int i = 2; i <= 9; i++) drain(8'(i));
        chk_empty("fullpop_drained");

        // Pop while holding one entry as a new byte lands
        good_frame(8'h11);
        send_bits(frame(8'h22, 1'b1, 1'b1), 0, 9);
        stop_bit(1'b1, 0, 1, 8'h00);
        drain(8'h22);
        chk_empty("onepop_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end
endmodule
